// File: rtl/zmem_access.sv
// Z80 memory-access sequencer: picks the pager window, forms the ROM/RAM
// address, drives the DRAM arbiter req/ack handshake, stalls the Z80 clock on
// RAM reads and drops writes to ROM or write-protected windows.
//
// Ports:
//   fclk, rst          system clock, async active-high reset
//   zpos, zneg         Z80 clock edge strobes (one fclk wide)
//   za, zd_in          Z80 address bus and write data
//   mreq_n, rd_n, wr_n, rfsh_n  Z80 bus controls
//   win_page           per-window pages, window w at [8w+7:8w]
//   win_romnram        per-window 1=ROM
//   win_wrdisable      per-window write protect
//   cpu_req/rnw/addr/wrdata, cpu_ack/rddata  DRAM arbiter handshake
//   rom_addr, rom_cs_n ROM interface
//   zd_out, zd_ena     data back to the Z80
//   zclk_stall         hold the Z80 clock during a RAM read
//   wr_blocked         1-cycle pulse when a write is dropped
module zmem_access #(
  parameter int STALL_MIN = 2
) (
  input  logic        fclk,
  input  logic        rst,
  input  logic        zpos,
  input  logic        zneg,
  input  logic [15:0] za,
  input  logic [7:0]  zd_in,
  input  logic        mreq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  input  logic [31:0] win_page,
  input  logic [3:0]  win_romnram,
  input  logic [3:0]  win_wrdisable,
  output logic        cpu_req,
  output logic        cpu_rnw,
  output logic [21:0] cpu_addr,
  output logic [7:0]  cpu_wrdata,
  input  logic        cpu_ack,
  input  logic [7:0]  cpu_rddata,
  output logic [18:0] rom_addr,
  output logic        rom_cs_n,
  output logic [7:0]  zd_out,
  output logic        zd_ena,
  output logic        zclk_stall,
  output logic        wr_blocked
);

  localparam int CW = $clog2(STALL_MIN + 1) + 1;
  localparam logic [CW-1:0] SMIN = CW'(STALL_MIN);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    ROM_RD,
    WR_DROP,
    RAM_REQ,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic        req_q, req_d;
  logic        rnw_q, rnw_d;
  logic [21:0] addr_q, addr_d;
  logic [7:0]  wrdata_q, wrdata_d;
  logic [18:0] rom_addr_q, rom_addr_d;
  logic        rom_cs_n_q, rom_cs_n_d;
  logic [7:0]  zd_out_q, zd_out_d;
  logic        zd_ena_q, zd_ena_d;
  logic        stall_q, stall_d;
  logic        done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        blk_q, blk_d;

  logic [1:0] w;
  logic [7:0] pg;
  logic       rom_w;
  logic       wp_w;
  logic       is_rd;
  logic       is_wr;
  logic       start;

  // zpos is part of the bus-strobe bundle but nothing here needs it.
  logic unused_zpos;
  assign unused_zpos = zpos;

  assign w     = za[15:14];
  assign pg    = win_page[{w, 3'b000} +: 8];
  assign rom_w = win_romnram[w];
  assign wp_w  = win_wrdisable[w];
  assign is_rd = ~rd_n;
  assign is_wr = ~wr_n;
  assign start = zneg & (state_q == IDLE) & ~mreq_n
               & rfsh_n & (is_rd | is_wr);

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    rnw_d      = rnw_q;
    addr_d     = addr_q;
    wrdata_d   = wrdata_q;
    rom_addr_d = rom_addr_q;
    rom_cs_n_d = rom_cs_n_q;
    zd_out_d   = zd_out_q;
    zd_ena_d   = zd_ena_q;
    stall_d    = stall_q;
    done_d     = done_q;
    cnt_d      = cnt_q;
    blk_d      = 1'b0;

    // Stall ends once read data is back and the minimum hold has elapsed.
    if (stall_q) begin
      if (done_q && (cnt_q >= SMIN)) begin
        stall_d = 1'b0;
      end else if (cnt_q < SMIN) begin
        cnt_d = cnt_q + ONE;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (is_rd && rom_w) begin
            state_d    = ROM_RD;
            rom_cs_n_d = 1'b0;
            zd_ena_d   = 1'b1;
            rom_addr_d = {pg[4:0], za[13:0]};
          end else if (!is_rd && (rom_w || wp_w)) begin
            state_d = WR_DROP;
            blk_d   = 1'b1;
          end else begin
            state_d  = RAM_REQ;
            req_d    = 1'b1;
            rnw_d    = is_rd;
            addr_d   = {pg, za[13:0]};
            wrdata_d = zd_in;
            stall_d  = is_rd;
            cnt_d    = ONE;
            done_d   = 1'b0;
          end
        end
      end
      // An aborted cycle (mreq_n high) still completes here.
      RAM_REQ: begin
        if (cpu_ack) begin
          req_d   = 1'b0;
          state_d = HOLD;
          if (rnw_q) begin
            zd_out_d = cpu_rddata;
            zd_ena_d = 1'b1;
            done_d   = 1'b1;
          end
        end
      end
      HOLD, ROM_RD, WR_DROP: begin
        if (mreq_n) begin
          state_d    = IDLE;
          zd_ena_d   = 1'b0;
          rom_cs_n_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      rnw_q      <= 1'b1;
      addr_q     <= '0;
      wrdata_q   <= '0;
      rom_addr_q <= '0;
      rom_cs_n_q <= 1'b1;
      zd_out_q   <= '0;
      zd_ena_q   <= 1'b0;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      blk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      rnw_q      <= rnw_d;
      addr_q     <= addr_d;
      wrdata_q   <= wrdata_d;
      rom_addr_q <= rom_addr_d;
      rom_cs_n_q <= rom_cs_n_d;
      zd_out_q   <= zd_out_d;
      zd_ena_q   <= zd_ena_d;
      stall_q    <= stall_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      blk_q      <= blk_d;
    end
  end

  assign cpu_req    = req_q;
  assign cpu_rnw    = rnw_q;
  assign cpu_addr   = addr_q;
  assign cpu_wrdata = wrdata_q;
  assign rom_addr   = rom_addr_q;
  assign rom_cs_n   = rom_cs_n_q;
  assign zd_out     = zd_out_q;
  assign zd_ena     = zd_ena_q;
  assign zclk_stall = stall_q;
  assign wr_blocked = blk_q;

endmodule
